// File: rtl/solver_core_scheduler.sv
// solver_core_scheduler: round-robin dispatch of job IDs onto a pool of solver
// cores, round-robin collection of their results, per-job result tagging and
// a wrapping batch total.
// Optional build macro SCHED_PERF_CNT_EN adds batch_cycles / core_util counters.
module solver_core_scheduler #(
  parameter int unsigned CORE_COUNT   = 4,
  parameter int unsigned JOB_ID_WIDTH = 8,
  parameter int unsigned RESULT_WIDTH = 4,
  parameter int unsigned SUM_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               job_valid,
  input  logic [JOB_ID_WIDTH-1:0]            job_id,
  input  logic                               job_last,
  output logic                               job_ready,
  output logic [JOB_ID_WIDTH-1:0]            dispatch_id,
  output logic [CORE_COUNT-1:0]              core_tx_valid,
  input  logic [CORE_COUNT-1:0]              core_ready,
  output logic [CORE_COUNT-1:0]              core_rx_ready,
  input  logic [CORE_COUNT-1:0]              core_result_valid,
  input  logic [CORE_COUNT*RESULT_WIDTH-1:0] core_result,
  output logic                               result_valid,
  output logic [JOB_ID_WIDTH-1:0]            result_id,
  output logic [RESULT_WIDTH-1:0]            result_value,
  output logic [SUM_WIDTH-1:0]               total_sum,
  output logic                               total_valid,
  output logic [$clog2(CORE_COUNT+1)-1:0]    busy_count
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                        batch_cycles,
  output logic [31:0]                        core_util
`endif
);

  localparam int unsigned PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int unsigned CNT_W = $clog2(CORE_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CORE_COUNT-1:0]   busy, busy_nxt;
  logic [JOB_ID_WIDTH-1:0] id_table [CORE_COUNT];
  logic [PTR_W-1:0]        dptr, cptr;

  logic [CORE_COUNT-1:0]   free, eligible;
  logic                    disp_hit, col_hit;
  logic [PTR_W-1:0]        disp_idx, col_idx, scan_idx;
  logic [CORE_COUNT-1:0]   col_onehot;
  logic [RESULT_WIDTH-1:0] col_result;
  logic                    accept, collect, first_accept, drain_done;
  logic [CNT_W-1:0]        busy_pop;

  // (base + off) mod CORE_COUNT, valid for base, off < CORE_COUNT
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(off);
    if (s >= (PTR_W+1)'(CORE_COUNT)) s = s - (PTR_W+1)'(CORE_COUNT);
    return s[PTR_W-1:0];
  endfunction

  // Round-robin searches for the dispatch target and the collect source
  always_comb begin
    free     = core_ready & ~busy;
    eligible = core_result_valid & busy;
    disp_hit = 1'b0;
    disp_idx = '0;
    col_hit  = 1'b0;
    col_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < CORE_COUNT; i++) begin
      scan_idx = wrap_add(dptr, i);
      if (!disp_hit && free[scan_idx]) begin
        disp_hit = 1'b1;
        disp_idx = scan_idx;
      end
      scan_idx = wrap_add(cptr, i);
      if (!col_hit && eligible[scan_idx]) begin
        col_hit = 1'b1;
        col_idx = scan_idx;
      end
    end
  end

  // FSM next state plus the same-cycle handshake outputs
  always_comb begin
    state_nxt     = state;
    job_ready     = 1'b0;
    accept        = 1'b0;
    first_accept  = 1'b0;
    drain_done    = 1'b0;
    core_tx_valid = '0;
    core_rx_ready = '0;
    col_onehot    = '0;
    collect       = col_hit;
    dispatch_id   = job_id;

    job_ready = ((state == ST_IDLE) || (state == ST_RUN)) && disp_hit;
    accept    = job_valid && job_ready;
    if (accept) core_tx_valid = CORE_COUNT'(1) << disp_idx;
    if (col_hit) col_onehot = CORE_COUNT'(1) << col_idx;
    core_rx_ready = col_onehot;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          first_accept = 1'b1;
          state_nxt    = job_last ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && job_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((busy == '0) && !col_hit) begin
          drain_done = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result mux, next busy mask and its population count
  always_comb begin
    col_result = '0;
    for (int unsigned k = 0; k < CORE_COUNT; k++) begin
      if (col_onehot[k]) col_result = core_result[k*RESULT_WIDTH +: RESULT_WIDTH];
    end
    busy_nxt = busy;
    if (accept) busy_nxt[disp_idx] = 1'b1;
    if (collect) busy_nxt[col_idx] = 1'b0;
    busy_pop = '0;
    for (int unsigned k = 0; k < CORE_COUNT; k++) begin
      busy_pop = busy_pop + CNT_W'(busy_nxt[k]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Busy tracking, ID table, pointers, result and batch-total registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= '0;
      dptr         <= '0;
      cptr         <= '0;
      busy_count   <= '0;
      result_valid <= 1'b0;
      result_id    <= '0;
      result_value <= '0;
      total_sum    <= '0;
      total_valid  <= 1'b0;
      for (int unsigned k = 0; k < CORE_COUNT; k++) id_table[k] <= '0;
    end else begin
      busy         <= busy_nxt;
      busy_count   <= busy_pop;
      result_valid <= collect;
      total_valid  <= drain_done;
      if (accept) begin
        id_table[disp_idx] <= job_id;
        dptr               <= wrap_add(disp_idx, 1);
      end
      if (collect) begin
        cptr         <= wrap_add(col_idx, 1);
        result_id    <= id_table[col_idx];
        result_value <= col_result;
      end
      // A first accept implies an empty busy mask, so no collect can coincide
      if (first_accept)  total_sum <= '0;
      else if (collect)  total_sum <= total_sum + SUM_WIDTH'(col_result);
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Batch window counters: first accept (inclusive) up to DONE (exclusive)
  always_ff @(posedge clk) begin
    if (reset) begin
      batch_cycles <= '0;
      core_util    <= '0;
    end else if (first_accept) begin
      batch_cycles <= 32'd1;
      core_util    <= 32'(busy_count);
    end else if ((state == ST_RUN) || (state == ST_DRAIN)) begin
      batch_cycles <= batch_cycles + 32'd1;
      core_util    <= core_util + 32'(busy_count);
    end
  end
`endif

endmodule
